// File: rtl/garden_pkg.sv
// Shared types for the garden scheduler: channel ids, BCD time, table entry, FSM state.
package garden_pkg;

   localparam logic [1:0] CH_LIGHT    = 2'd0;
   localparam logic [1:0] CH_GATE     = 2'd1;
   localparam logic [1:0] CH_FOUNTAIN = 2'd2;

   typedef logic [15:0] bcd_time_t;   // {hr2,hr1,min2,min1}

   typedef struct packed {
      bcd_time_t  start;
      bcd_time_t  stop;
      logic [1:0] ch;
      logic       valid;
   } sched_entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_UPDATE} state_t;

   // Legal HH:MM in packed BCD: 00:00 .. 23:59
   function automatic logic bcd_time_ok(input bcd_time_t t);
      logic [3:0] h2, h1, m2, m1;
      {h2, h1, m2, m1} = t;
      return (h2 <= 4'd2) && (h1 <= 4'd9) && (m2 <= 4'd5) && (m1 <= 4'd9) &&
             !((h2 == 4'd2) && (h1 > 4'd3));
   endfunction

endpackage

// File: rtl/garden_window_cmp.sv
// Combinational hit test of one table entry against the latched time.
// Midnight-spanning windows are only evaluated when GARDEN_SCHED_WRAP_EN is defined.
module garden_window_cmp
   import garden_pkg::*;
(
   input  sched_entry_t entry,
   input  bcd_time_t    t,
   output logic         hit
);

   always_comb begin
      hit = 1'b0;
      if (entry.valid) begin
         if (entry.start < entry.stop)
            hit = (t >= entry.start) && (t < entry.stop);
`ifdef GARDEN_SCHED_WRAP_EN
         else if (entry.start > entry.stop)
            hit = (t >= entry.start) || (t < entry.stop);
`endif
      end
   end

endmodule

// File: rtl/garden_scheduler.sv
// Time-of-day window scheduler: scans the entry table one entry per cycle on each
// tick and drives registered channel enables with start/stop pulses. Option: GARDEN_SCHED_WRAP_EN.
module garden_scheduler
   import garden_pkg::*;
#(
   parameter int NUM_WIN = 4,
   parameter int NUM_CH  = 3
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic [15:0]                time_bcd,
   input  logic                       cfg_we,
   input  logic [$clog2(NUM_WIN)-1:0] cfg_idx,
   input  logic [15:0]                cfg_start,
   input  logic [15:0]                cfg_stop,
   input  logic [1:0]                 cfg_ch,
   input  logic                       cfg_valid,
   output logic                       cfg_busy,
   output logic                       cfg_rej,
   input  logic [NUM_CH-1:0]          man_on,
   input  logic [NUM_CH-1:0]          man_off,
   output logic [NUM_CH-1:0]          ch_en,
   output logic [NUM_CH-1:0]          ch_start,
   output logic [NUM_CH-1:0]          ch_stop
);

   localparam int            IW   = $clog2(NUM_WIN);
   localparam logic [IW-1:0] LAST = IW'(NUM_WIN - 1);

   state_t            state, state_nxt;
   sched_entry_t      tbl [NUM_WIN];
   sched_entry_t      cur;
   bcd_time_t         t_q;
   logic [IW-1:0]     idx;
   logic [NUM_CH-1:0] acc, acc_nxt, sched_q, sched_next, en_nxt;
   logic              pending, pending_nxt, start_scan, wr_ok, hit;

   assign cur = tbl[idx];

   garden_window_cmp u_cmp (.entry(cur), .t(t_q), .hit(hit));

   assign cfg_busy   = (state != ST_IDLE);
   assign start_scan = (state == ST_IDLE) && (tick || pending);
   assign wr_ok      = cfg_we && (state == ST_IDLE) && !tick &&
                       bcd_time_ok(cfg_start) && bcd_time_ok(cfg_stop);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_scan) state_nxt = ST_SCAN;
         ST_SCAN:   if (idx == LAST) state_nxt = ST_UPDATE;
         ST_UPDATE: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Entries aimed at a channel this instance does not have never match here
   always_comb begin
      acc_nxt = acc;
      for (int c = 0; c < NUM_CH; c++)
         if (hit && (cur.ch == 2'(c))) acc_nxt[c] = 1'b1;
   end

   // A new request (late tick or accepted write) wins over the clear at scan start
   always_comb begin
      pending_nxt = pending;
      if (start_scan) pending_nxt = 1'b0;
      if ((tick && (state != ST_IDLE)) || wr_ok) pending_nxt = 1'b1;
   end

   assign sched_next = (state == ST_UPDATE) ? acc : sched_q;
   assign en_nxt     = (sched_next | man_on) & ~man_off;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_WIN; i++) tbl[i] <= '0;
         t_q      <= '0;
         idx      <= '0;
         acc      <= '0;
         sched_q  <= '0;
         pending  <= 1'b0;
         cfg_rej  <= 1'b0;
         ch_en    <= '0;
         ch_start <= '0;
         ch_stop  <= '0;
      end else begin
         pending  <= pending_nxt;
         cfg_rej  <= cfg_we && !wr_ok;
         ch_en    <= en_nxt;
         ch_start <= en_nxt & ~ch_en;
         ch_stop  <= ~en_nxt & ch_en;
         if (wr_ok)
            tbl[cfg_idx] <= '{start: cfg_start, stop: cfg_stop, ch: cfg_ch, valid: cfg_valid};
         if (start_scan) begin
            t_q <= time_bcd;
            acc <= '0;
            idx <= '0;
         end else if (state == ST_SCAN) begin
            acc <= acc_nxt;
            if (idx != LAST) idx <= idx + 1'b1;
         end
         if (state == ST_UPDATE) sched_q <= acc;
      end
   end

endmodule
